sram_burst_master: RTL and testbench
====================================

Name: sram_burst_master

Overview:
Initiator-side controller for the single-port synchronous SRAM block. Accepts burst commands (start address, beat count, read/write) over a valid/ready command channel. Streams write data into the SRAM and streams read data back out, absorbing the SRAM's one-cycle read latency and consumer backpressure with a 2-entry output buffer. Sits between sprite/frame-buffer logic and the SRAM instance.

Parameters:
ADDR_W, 8, SRAM address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 8, data word width.
LEN_W, 8, width of cmd_len; burst length is cmd_len+1 beats (1..2^LEN_W).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high only in IDLE.
cmd_write  in  1  1 = write burst, 0 = read burst.
cmd_addr  in  ADDR_W  first beat address.
cmd_len  in  LEN_W  beats minus one.
wr_valid  in  1  write data offered.
wr_ready  out  1  write data accepted (WRITE state only).
wr_data  in  DATA_W  write word.
rd_valid  out  1  read word available.
rd_ready  in  1  consumer accepts read word.
rd_data  out  DATA_W  read word (buffer head).
done  out  1  one-cycle pulse at burst completion.
busy  out  1  state != IDLE.
mem_addr  out  ADDR_W  to SRAM ADDR.
mem_we  out  1  to SRAM MemWrite.
mem_wdata  out  DATA_W  to SRAM DATA.
mem_rdata  in  DATA_W  from SRAM DATA_OUT; valid the cycle after the address is presented with mem_we=0.

Behaviour:
- Reset (async, any state): state IDLE; cmd_ready=1; wr_ready=0; rd_valid=0; done=0; busy=0; mem_we=0; mem_addr=0; mem_wdata=0; buffer empty; pending flag cleared. An in-flight burst is abandoned with no done pulse.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: on cmd_valid&&cmd_ready, latch addr and remaining count (cmd_len+1), then go to WRITE or READ per cmd_write.
- WRITE: wr_ready=1. Each wr_valid beat drives mem_we=1, mem_addr=cur_addr, mem_wdata=wr_data combinationally in that same cycle, so the SRAM writes at that edge. Then addr+1 (wrap) and count-1. On the final beat, go to IDLE with done=1 in the next cycle. mem_we=0 whenever no beat is accepted.
- READ: issue a read (mem_addr=cur_addr, mem_we=0, set pending for next cycle) only when occupancy + pending - pop < 2, where pop = rd_valid&&rd_ready this cycle. After the final issue, go to DRAIN.
- Capture: mem_rdata is written into the buffer in the cycle after an issue, gated solely by pending. The SRAM reloads its output register every non-write cycle, so unpending mem_rdata is ignored.
- Buffer: 2-entry FIFO. rd_data = head; rd_valid = occupancy != 0. Simultaneous push and pop are allowed in the same cycle. Occupancy can never exceed 2; overflow is unreachable by construction.
- DRAIN: wait until pending == 0 and the buffer is empty, then go to IDLE. done=1 in the cycle after the last rd beat handshake.
- Latency: with rd_ready held high, first rd_valid arrives 2 cycles after command acceptance, then 1 beat/cycle.
- Wrap: an address of 2^ADDR_W-1 increments to 0. A burst longer than the SRAM depth rewrites or rereads from the start.
- cmd_valid outside IDLE is ignored. wr_valid outside WRITE is not accepted.

Optional Feature:
SRAM_BURST_MASTER_PERF_EN: when defined, adds outputs stall_cnt[15:0] and beat_cnt[15:0].
- stall_cnt counts READ/DRAIN cycles with rd_valid && !rd_ready.
- beat_cnt counts every read or write beat transferred.
- Both saturate at 16'hFFFF, clear on reset, and never clear otherwise.
When undefined, these ports and their logic are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package/header sram_pkg: state encoding localparams (IDLE=2'd0, WRITE=2'd1, READ=2'd2, DRAIN=2'd3) and the default ADDR_W/DATA_W/LEN_W values used by the SRAM and all its initiators.
- One natural sub-module: sram_rd_skid, the 2-entry FIFO with push/pop/occupancy outputs.

Test Plan:
- Write burst: addr=8'h10, len=3, data 8'hA1..A4, wr_valid high. Expect mem_we high 4 consecutive cycles, addrs 10..13, then done pulse, then cmd_ready=1.
- Read back: addr=8'h10, len=3, rd_ready=1. Expect rd_data A1,A2,A3,A4 on consecutive cycles, first beat 2 cycles after accept, done after the 4th beat.
- Backpressure: read len=7 with rd_ready toggling 1,0,0,1,... Expect no lost or duplicated words, occupancy ≤2, and order preserved.
- Wrap: write addr=8'hFE, len=3, data 11,22,33,44. Expect writes to FE,FF,00,01. A read from FE returns the same 4 words.
- Reset mid-burst: rst_n low during the 3rd beat of a len=7 read. Expect immediately rd_valid=0, busy=0, mem_we=0, and no done pulse; a following command completes normally.
- PERF (macro defined): after the backpressure test, stall_cnt equals the count of rd_valid&&!rd_ready cycles and beat_cnt equals the total beats.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the single-port SRAM and its initiators:
// burst-master state encoding and default bus widths.
package sram_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Performance counters hold at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry read-data FIFO that absorbs the SRAM read latency and
// consumer backpressure; push and pop may coincide.
module sram_rd_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occupancy,
  output logic              valid
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign occupancy = count;
  assign valid     = (count != 2'd0);

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for the single-port synchronous SRAM.
// Define SRAM_BURST_MASTER_PERF_EN to add the stall_cnt/beat_cnt counters.
module sram_burst_master
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int LEN_W  = SRAM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef SRAM_BURST_MASTER_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       beat_cnt
`endif
);

  localparam int CNT_W = LEN_W + 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic              pending;
  logic              done_r;
  logic              wr_beat;
  logic              issue;
  logic              pop;
  logic              last;
  logic              rd_finish;
  logic [1:0]        occ;
  logic [2:0]        inflight;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WRITE);
  assign wr_beat   = wr_ready && wr_valid;
  assign pop       = rd_valid && rd_ready;
  assign last      = (remaining == CNT_W'(1));

  // Only issue a read when the word is guaranteed a buffer slot next cycle.
  assign inflight  = {1'b0, occ} + {2'b00, pending};
  assign issue     = (state == READ) && (inflight < (3'd2 + {2'b00, pop}));
  assign rd_finish = !pending && ((occ == 2'd0) || ((occ == 2'd1) && pop));

  assign mem_we    = wr_beat;
  assign mem_addr  = cur_addr;
  assign mem_wdata = wr_beat ? wr_data : '0;
  assign done      = done_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_write ? WRITE : READ;
      WRITE:   if (wr_beat && last) state_nxt = IDLE;
      READ:    if (issue && last) state_nxt = DRAIN;
      DRAIN:   if (rd_finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pending   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= issue;
      done_r  <= (state != IDLE) && (state_nxt == IDLE);
      if ((state == IDLE) && cmd_valid) begin
        cur_addr  <= cmd_addr;
        remaining <= {1'b0, cmd_len} + CNT_W'(1);
      end else if (wr_beat || issue) begin
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  // The SRAM output is only meaningful the cycle after an issued read.
  sram_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pending),
    .push_data (mem_rdata),
    .pop       (pop),
    .head      (rd_data),
    .occupancy (occ),
    .valid     (rd_valid)
  );

`ifdef SRAM_BURST_MASTER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      beat_cnt  <= 16'd0;
    end else begin
      if (((state == READ) || (state == DRAIN)) && rd_valid && !rd_ready) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end
      if (wr_beat || pop) begin
        beat_cnt <= sat_inc16(beat_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master with a behavioural 256x8 SRAM.
module tb_sram_burst_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_len = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
`ifdef SRAM_BURST_MASTER_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] beat_cnt;
  logic [15:0] stall_base;
  logic [15:0] beat_base;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] sram [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    else        mem_rdata <= sram[mem_addr];
  end

  sram_burst_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .done      (done),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef SRAM_BURST_MASTER_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .beat_cnt  (beat_cnt)
`endif
  );

  // data holds write words for writes and expected read words for reads
  typedef struct {
    logic            write;
    logic [7:0]      addr;
    logic [7:0]      len;
    logic [3:0][7:0] data;
    logic [3:0][7:0] exp_addr;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one burst of up to 4 beats with wr_valid/rd_ready held high.
  task automatic applyStimulus(input vec_t v);
    int nb;
    int k;
    int first;
    int donecyc;
    nb = int'(v.len) + 1;
    @(negedge clk);
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    rd_ready  = 1'b1;
    wr_valid  = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (v.write) begin
      for (int i = 0; i < nb; i++) begin
        if (i > 0) @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = v.data[i];
        #1;
        checkOutput("wr_we", mem_we, 1);
        checkOutput("wr_addr", mem_addr, v.exp_addr[i]);
        checkOutput("wr_wdata", mem_wdata, v.data[i]);
        checkOutput("wr_no_early_done", done, 0);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      checkOutput("wr_done", done, 1);
      checkOutput("wr_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      #1;
      checkOutput("wr_done_pulse", done, 0);
    end else begin
      k = 0;
      first = -1;
      donecyc = -1;
      for (int c = 1; c <= 20 && donecyc < 0; c++) begin
        if (c > 1) @(negedge clk);
        #1;
        if (c <= nb) begin
          checkOutput("rd_issue_addr", mem_addr, v.exp_addr[c-1]);
          checkOutput("rd_issue_we", mem_we, 0);
        end
        if (rd_valid) begin
          if (first < 0) first = c;
          if (k < nb) checkOutput("rd_data", rd_data, v.data[k]);
          k++;
        end
        if (done) donecyc = c;
      end
      checkOutput("rd_first_latency", first, 3);
      checkOutput("rd_beats", k, nb);
      checkOutput("rd_done_cycle", donecyc, nb + 3);
      checkOutput("rd_cmd_ready", cmd_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int stalls;
    int donecyc;
    int beats;
    int seen;
    vec_t rv;

    for (int i = 0; i < 256; i++) sram[i] = 8'h00;

    vecs[0] = '{1'b1, 8'h10, 8'd3, {8'hA4, 8'hA3, 8'hA2, 8'hA1}, {8'h13, 8'h12, 8'h11, 8'h10}};
    vecs[1] = '{1'b0, 8'h10, 8'd3, {8'hA4, 8'hA3, 8'hA2, 8'hA1}, {8'h13, 8'h12, 8'h11, 8'h10}};
    vecs[2] = '{1'b1, 8'hFE, 8'd3, {8'h44, 8'h33, 8'h22, 8'h11}, {8'h01, 8'h00, 8'hFF, 8'hFE}};
    vecs[3] = '{1'b0, 8'hFE, 8'd3, {8'h44, 8'h33, 8'h22, 8'h11}, {8'h01, 8'h00, 8'hFF, 8'hFE}};
    vecs[4] = '{1'b1, 8'h80, 8'd0, {8'h00, 8'h00, 8'h00, 8'h5A}, {8'h00, 8'h00, 8'h00, 8'h80}};
    vecs[5] = '{1'b0, 8'h80, 8'd0, {8'h00, 8'h00, 8'h00, 8'h5A}, {8'h00, 8'h00, 8'h00, 8'h80}};
    vecs[6] = '{1'b0, 8'h12, 8'd1, {8'h00, 8'h00, 8'hA4, 8'hA3}, {8'h00, 8'h00, 8'h13, 8'h12}};

    // Reset state
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_wr_ready", wr_ready, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
`ifdef SRAM_BURST_MASTER_PERF_EN
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_beat_cnt", beat_cnt, 0);
`endif
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // wr_valid in IDLE must not reach the SRAM
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    #1;
    checkOutput("idle_wr_ready", wr_ready, 0);
    checkOutput("idle_mem_we", mem_we, 0);
    wr_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    // Write with a wr_valid gap while a second command is offered
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h20;
    cmd_len   = 8'd1;
    @(negedge clk);
    cmd_write = 1'b0;
    cmd_addr  = 8'hC0;
    wr_valid  = 1'b0;
    #1;
    checkOutput("gap_cmd_ready", cmd_ready, 0);
    checkOutput("gap_busy", busy, 1);
    checkOutput("gap_wr_ready", wr_ready, 1);
    checkOutput("gap_mem_we", mem_we, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 8'h77;
    #1;
    checkOutput("gap_beat0_we", mem_we, 1);
    checkOutput("gap_beat0_addr", mem_addr, 8'h20);
    @(negedge clk);
    wr_data = 8'h88;
    #1;
    checkOutput("gap_beat1_addr", mem_addr, 8'h21);
    checkOutput("gap_beat1_wdata", mem_wdata, 8'h88);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checkOutput("gap_done", done, 1);
    checkOutput("gap_sram20", sram[8'h20], 8'h77);
    checkOutput("gap_sram21", sram[8'h21], 8'h88);
    checkOutput("gap_sramC0", sram[8'hC0], 8'h00);

    // Fill 0x40..0x47 with 0x60..0x67
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h40;
    cmd_len   = 8'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'h60 + 8'(i);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checkOutput("fill_done", done, 1);

    // Backpressured read, rd_ready pattern 1,0,0 repeating
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h40;
    cmd_len   = 8'd7;
    rd_ready  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
`ifdef SRAM_BURST_MASTER_PERF_EN
    stall_base = stall_cnt;
    beat_base  = beat_cnt;
`endif
    k = 0;
    stalls = 0;
    donecyc = -1;
    for (int c = 0; c < 80 && donecyc < 0; c++) begin
      if (c > 0) @(negedge clk);
      rd_ready = ((c % 3) == 0);
      #1;
      if (rd_valid && rd_ready) begin
        if (k < 8) checkOutput("bp_rd_data", rd_data, 8'h60 + 8'(k));
        k++;
      end
      if (rd_valid && !rd_ready) stalls++;
      if (done) donecyc = c;
    end
    checkOutput("bp_beats", k, 8);
    checkOutput("bp_done_seen", (donecyc >= 0), 1);
`ifdef SRAM_BURST_MASTER_PERF_EN
    checkOutput("perf_stall_cnt", stall_cnt - stall_base, 16'(stalls));
    checkOutput("perf_beat_cnt", beat_cnt - beat_base, 16'd8);
`endif
    rd_ready = 1'b1;

    // Reset during the 3rd beat of a len=7 read
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 8'h40;
    cmd_len   = 8'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rd_valid) beats++;
    end
    checkOutput("rst_mid_third_beat", beats, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_rd_valid", rd_valid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_mem_we", mem_we, 0);
    checkOutput("rst_mid_cmd_ready", cmd_ready, 1);
`ifdef SRAM_BURST_MASTER_PERF_EN
    checkOutput("rst_mid_beat_cnt", beat_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1;
    end
    checkOutput("rst_mid_no_done", seen, 0);

    rv = '{1'b0, 8'h40, 8'd3, {8'h63, 8'h62, 8'h61, 8'h60}, {8'h43, 8'h42, 8'h41, 8'h40}};
    applyStimulus(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
